// File: rtl/mini_pkg.sv
// Shared types for the Mini solver hierarchy: sequencer states and result codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mini_pkg;

    localparam int LIT_W  = 32;
    localparam int STAT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        LOAD     = 3'd2,
        START    = 3'd3,
        SOLVE    = 3'd4,
        REPORT   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_SAT     = 2'd1,
        RES_UNSAT   = 2'd2,
        RES_TIMEOUT = 2'd3
    } res_code_t;

endpackage

// File: rtl/mini_rr_arbiter.sv
// Round-robin client selector: grants the first requester at or after the search base.
// Latency: grant is combinational; the base moves on the cycle after advance.
// Backpressure: none; the caller decides when a grant is consumed via advance.
module mini_rr_arbiter #(
    parameter  int NUM_CLIENTS = 4,
    localparam int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    input  logic                   advance,
    output logic [IDX_W-1:0]       grant,
    output logic                   grant_valid
);

    // Index where the next search begins; one past the last served client.
    logic [IDX_W-1:0] r_base;

    // Move the search base just past the client whose job was handed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
        end else if (advance) begin
            r_base <= (last == IDX_W'(NUM_CLIENTS - 1)) ? '0 : last + IDX_W'(1);
        end
    end

    // Scan from the far end back towards the base so the closest requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            int j;
            j = int'(r_base) + i;
            if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
            if (req[j]) begin
                grant       = IDX_W'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mini_job_sequencer.sv
// Shares one solver core among NUM_CLIENTS requesters: reset core, load literals, start, collect result.
// Latency: req -> first LOAD cycle CORE_RST_CYCLES+2; last literal -> start 1; core_done -> res_valid 1.
// Backpressure: literal stream passes core_load_ready straight to the granted client; result held until res_ready.
// Optional macro MINI_SEQ_TIMEOUT_EN adds the cycle-budget counter and RES_TIMEOUT path.
module mini_job_sequencer
    import mini_pkg::*;
#(
    parameter  int NUM_CLIENTS     = 4,
    parameter  int TIMEOUT_W       = 32,
    parameter  int CORE_RST_CYCLES = 4,
    localparam int IDX_W           = $clog2(NUM_CLIENTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CLIENTS-1:0]       req,
    input  logic [NUM_CLIENTS-1:0]       cl_valid,
    input  logic [NUM_CLIENTS-1:0][31:0] cl_literal,
    input  logic [NUM_CLIENTS-1:0]       cl_clause_end,
    input  logic [NUM_CLIENTS-1:0]       cl_last,
    output logic [NUM_CLIENTS-1:0]       cl_ready,
    input  logic [TIMEOUT_W-1:0]         cycle_budget,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [IDX_W-1:0]             res_client,
    output logic [1:0]                   res_code,
    output logic [31:0]                  res_conflicts,
    output logic [31:0]                  res_decisions,
    output logic                         busy,
    output logic                         core_rst_n,
    output logic                         core_start_solve,
    input  logic                         core_done,
    input  logic                         core_sat,
    input  logic                         core_unsat,
    output logic                         core_load_valid,
    output logic [31:0]                  core_load_literal,
    output logic                         core_load_clause_end,
    input  logic                         core_load_ready,
    input  logic [31:0]                  core_conflict_count,
    input  logic [31:0]                  core_decision_count
);

    localparam int RC_W = $clog2(CORE_RST_CYCLES + 1);

    seq_state_t        r_state;
    logic [IDX_W-1:0]  r_grant;
    logic [RC_W-1:0]   r_rst_cnt;
    logic              r_core_rst_n;
    logic              r_start_solve;
    logic              r_res_valid;
    logic [IDX_W-1:0]  r_res_client;
    res_code_t         r_res_code;
    logic [STAT_W-1:0] r_res_conflicts;
    logic [STAT_W-1:0] r_res_decisions;

    logic [IDX_W-1:0]  w_arb_grant;
    logic              w_arb_valid;
    logic              w_advance;
    logic              w_load_fire;

`ifdef MINI_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_budget;
    logic [TIMEOUT_W-1:0] r_cycles;
    logic [TIMEOUT_W-1:0] w_cycles_next;
    logic                 w_unused;

    assign w_cycles_next = (&r_cycles) ? r_cycles : r_cycles + TIMEOUT_W'(1);
    assign w_unused      = core_unsat;
`else
    logic w_unused;

    assign w_unused = core_unsat ^ (^cycle_budget);
`endif

    assign w_advance   = (r_state == REPORT) && res_ready;
    assign w_load_fire = (r_state == LOAD) && cl_valid[r_grant] && core_load_ready;

    mini_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .last        (r_grant),
        .advance     (w_advance),
        .grant       (w_arb_grant),
        .grant_valid (w_arb_valid)
    );

    // Literal stream is a direct connection between the granted client and the core during LOAD.
    always_comb begin
        cl_ready             = '0;
        core_load_valid      = 1'b0;
        core_load_literal    = '0;
        core_load_clause_end = 1'b0;
        if (r_state == LOAD) begin
            core_load_valid      = cl_valid[r_grant];
            core_load_literal    = cl_literal[r_grant];
            core_load_clause_end = cl_clause_end[r_grant];
            cl_ready[r_grant]    = core_load_ready;
        end
    end

    // Job FSM: every control and result output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_rst_cnt       <= '0;
            r_core_rst_n    <= 1'b0;
            r_start_solve   <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_client    <= '0;
            r_res_code      <= RES_NONE;
            r_res_conflicts <= '0;
            r_res_decisions <= '0;
`ifdef MINI_SEQ_TIMEOUT_EN
            r_budget        <= '0;
            r_cycles        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant      <= w_arb_grant;
                        r_rst_cnt    <= '0;
                        r_core_rst_n <= 1'b0;
                        r_state      <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    // Hold reset low for CORE_RST_CYCLES, then one released settle cycle.
                    if (r_core_rst_n) begin
                        r_state <= LOAD;
                    end else if (r_rst_cnt == RC_W'(CORE_RST_CYCLES - 1)) begin
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                LOAD: begin
                    if (w_load_fire && cl_last[r_grant] && cl_clause_end[r_grant]) begin
                        r_start_solve <= 1'b1;
                        r_state       <= START;
                    end
                end
                START: begin
                    r_start_solve <= 1'b0;
`ifdef MINI_SEQ_TIMEOUT_EN
                    r_budget      <= cycle_budget;
                    r_cycles      <= '0;
`endif
                    r_state       <= SOLVE;
                end
                SOLVE: begin
`ifdef MINI_SEQ_TIMEOUT_EN
                    r_cycles <= w_cycles_next;
`endif
                    // core_done is checked first so it wins a tie with budget expiry.
                    if (core_done) begin
                        r_res_code      <= core_sat ? RES_SAT : RES_UNSAT;
                        r_res_conflicts <= core_conflict_count;
                        r_res_decisions <= core_decision_count;
                        r_res_client    <= r_grant;
                        r_res_valid     <= 1'b1;
                        r_state         <= REPORT;
                    end
`ifdef MINI_SEQ_TIMEOUT_EN
                    else if ((r_budget != '0) && (w_cycles_next == r_budget)) begin
                        r_res_code      <= RES_TIMEOUT;
                        r_res_conflicts <= core_conflict_count;
                        r_res_decisions <= core_decision_count;
                        r_res_client    <= r_grant;
                        r_res_valid     <= 1'b1;
                        r_state         <= REPORT;
                    end
`endif
                end
                REPORT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy             = (r_state != IDLE);
    assign core_rst_n       = r_core_rst_n;
    assign core_start_solve = r_start_solve;
    assign res_valid        = r_res_valid;
    assign res_client       = r_res_client;
    assign res_code         = r_res_code;
    assign res_conflicts    = r_res_conflicts;
    assign res_decisions    = r_res_decisions;

endmodule

// File: tb/tb_mini_job_sequencer.sv
// Directed bench for mini_job_sequencer with a scripted core model driven from the stimulus.
// Latency: checks grant, start and result timing cycle-exactly at negedges.
// Backpressure: stalls the core load port once per job and holds res_ready low before the handshake.
module tb_mini_job_sequencer;
    import mini_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      cl_valid;
    logic [N-1:0][31:0] cl_literal;
    logic [N-1:0]      cl_clause_end;
    logic [N-1:0]      cl_last;
    logic [N-1:0]      cl_ready;
    logic [31:0]       cycle_budget;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_client;
    logic [1:0]        res_code;
    logic [31:0]       res_conflicts;
    logic [31:0]       res_decisions;
    logic              busy;
    logic              core_rst_n;
    logic              core_start_solve;
    logic              core_done;
    logic              core_sat;
    logic              core_unsat;
    logic              core_load_valid;
    logic [31:0]       core_load_literal;
    logic              core_load_clause_end;
    logic              core_load_ready;
    logic [31:0]       core_conflict_count;
    logic [31:0]       core_decision_count;

    always #5 clk = ~clk;

    mini_job_sequencer #(.NUM_CLIENTS(N), .TIMEOUT_W(32), .CORE_RST_CYCLES(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .cl_valid             (cl_valid),
        .cl_literal           (cl_literal),
        .cl_clause_end        (cl_clause_end),
        .cl_last              (cl_last),
        .cl_ready             (cl_ready),
        .cycle_budget         (cycle_budget),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_client           (res_client),
        .res_code             (res_code),
        .res_conflicts        (res_conflicts),
        .res_decisions        (res_decisions),
        .busy                 (busy),
        .core_rst_n           (core_rst_n),
        .core_start_solve     (core_start_solve),
        .core_done            (core_done),
        .core_sat             (core_sat),
        .core_unsat           (core_unsat),
        .core_load_valid      (core_load_valid),
        .core_load_literal    (core_load_literal),
        .core_load_clause_end (core_load_clause_end),
        .core_load_ready      (core_load_ready),
        .core_conflict_count  (core_conflict_count),
        .core_decision_count  (core_decision_count)
    );

    int total = 0;
    int bad   = 0;

    int mon_xfers     = 0;
    int mon_starts    = 0;
    int mon_multi_rdy = 0;

    int tb_lit[$];
    bit tb_ce[$];

    // Core-side observers: accepted literals, start pulses, and any multi-hot ready.
    always @(posedge clk) begin
        if (core_load_valid && core_load_ready) mon_xfers++;
        if (core_start_solve) mon_starts++;
    end

    always @(negedge clk) begin
        if ($countones(cl_ready) > 1) mon_multi_rdy++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One complete job: grant, core reset, load tb_lit/tb_ce, solve, report, handshake.
    // wait_cyc is the number of SOLVE cycles before core_done (or the budget for a timeout).
    task automatic run_job(input int c, input logic [N-1:0] rq, input bit keep,
                           input logic sat, input logic [31:0] confl, input logic [31:0] dec,
                           input int wait_cyc, input logic [31:0] budget, input logic [1:0] exp_code);
        int k;
        int zeros;
        int early;
        int x0;
        int s0;
        int n;
        logic [31:0] e;
        x0 = mon_xfers;
        s0 = mon_starts;
        n  = tb_lit.size();
        zeros = 0;
        early = 0;
        cycle_budget        = budget;
        core_conflict_count = confl;
        core_decision_count = dec;
        core_sat            = sat;
        core_unsat          = !sat;
        req = rq;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (!core_rst_n) zeros++;
            if (|cl_ready) break;
        end
        if (!keep) req = '0;
        chk("grant_latency", k, 6);
        chk("core_rst_low", zeros, 4);
        chk("grant_onehot", cl_ready, 64'(1 << c));
        for (int i = 0; i < n; i++) begin
            cl_literal[c]    = tb_lit[i];
            cl_clause_end[c] = tb_ce[i];
            cl_last[c]       = (i == n - 1);
            cl_valid[c]      = 1'b1;
            if (i == 1) begin
                core_load_ready = 1'b0;
                #1;
                chk("stall_ready", cl_ready[c], 0);
                @(negedge clk);
                core_load_ready = 1'b1;
            end
            #1;
            e = tb_lit[i];
            chk("lit_pass", core_load_literal, e);
            chk("ce_pass", core_load_clause_end, tb_ce[i]);
            @(negedge clk);
        end
        cl_valid[c]      = 1'b0;
        cl_last[c]       = 1'b0;
        cl_clause_end[c] = 1'b0;
        chk("xfers", mon_xfers - x0, n);
        chk("start_pulse", core_start_solve, 1);
        for (int j = 1; j <= wait_cyc + 1; j++) begin
            @(negedge clk);
            core_done = 1'b0;
            if (j == 1) chk("start_once", core_start_solve, 0);
            if (j <= wait_cyc) begin
                if (res_valid) early++;
                if (j == wait_cyc && exp_code != RES_TIMEOUT) core_done = 1'b1;
            end
        end
        core_done = 1'b0;
        chk("res_early", early, 0);
        chk("res_valid", res_valid, 1);
        chk("res_code", res_code, exp_code);
        chk("res_client", res_client, c);
        chk("res_conflicts", res_conflicts, confl);
        chk("res_decisions", res_decisions, dec);
        @(negedge clk);
        @(negedge clk);
        chk("res_hold", {res_valid, res_code}, {1'b1, exp_code});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after", busy, 0);
        chk("valid_drop", res_valid, 0);
        chk("starts", mon_starts - s0, 1);
    endtask

    initial begin
        int k;
        rst_n               = 1'b0;
        req                 = '0;
        cl_valid            = '0;
        cl_literal          = '0;
        cl_clause_end       = '0;
        cl_last             = '0;
        cycle_budget        = '0;
        res_ready           = 1'b0;
        core_done           = 1'b0;
        core_sat            = 1'b0;
        core_unsat          = 1'b0;
        core_load_ready     = 1'b1;
        core_conflict_count = '0;
        core_decision_count = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, res_valid, core_rst_n, core_start_solve, core_load_valid, cl_ready}, 0);
        chk("rst_res", {res_code, res_client, res_conflicts, res_decisions}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_core_rst", {busy, core_rst_n}, 0);

        // Single SAT job on client 0: (1 2)(-1 2)
        tb_lit = '{1, 2, -1, 2};
        tb_ce  = '{0, 1, 0, 1};
        run_job(0, 4'b0001, 1'b0, 1'b1, 32'd3, 32'd7, 4, 32'd0, RES_SAT);

        // Client 3 alone, leaves the pointer wrapped back to 0
        tb_lit = '{3, -4};
        tb_ce  = '{0, 1};
        run_job(3, 4'b1000, 1'b0, 1'b1, 32'd0, 32'd2, 2, 32'd0, RES_SAT);

        // Fairness: all four requesting for 8 back-to-back jobs
        tb_lit = '{7, -8};
        tb_ce  = '{1, 1};
        for (int j = 0; j < 8; j++) begin
            run_job(j % 4, 4'b1111, (j < 7), (j % 2 == 1), 32'(j), 32'(j + 10), 2, 32'd0,
                    (j % 2 == 1) ? RES_SAT : RES_UNSAT);
        end

`ifdef MINI_SEQ_TIMEOUT_EN
        // Budget 5 with no core_done: timeout six cycles after START
        tb_lit = '{1, 2, 3};
        tb_ce  = '{0, 0, 1};
        run_job(1, 4'b0010, 1'b0, 1'b0, 32'd7, 32'd9, 5, 32'd5, RES_TIMEOUT);
        // core_done on the budget cycle wins over the timeout
        run_job(1, 4'b0010, 1'b0, 1'b0, 32'd3, 32'd4, 3, 32'd3, RES_UNSAT);
`else
        // Budget is ignored: done after six cycles with budget 2 still reports SAT
        tb_lit = '{1, 2, 3};
        tb_ce  = '{0, 0, 1};
        run_job(1, 4'b0010, 1'b0, 1'b1, 32'd5, 32'd6, 6, 32'd2, RES_SAT);
`endif

        // UNSAT job on client 2: (1)(-1); pointer ends at 3
        tb_lit = '{1, -1};
        tb_ce  = '{1, 1};
        run_job(2, 4'b0100, 1'b0, 1'b0, 32'd1, 32'd1, 3, 32'd0, RES_UNSAT);

        // Reset in the middle of LOAD on client 3
        req = 4'b1000;
        k = 0;
        while (k < 20 && !cl_ready[3]) begin
            @(negedge clk);
            k++;
        end
        req = '0;
        chk("mid_grant", cl_ready, 4'b1000);
        cl_literal[3]    = 32'd5;
        cl_clause_end[3] = 1'b0;
        cl_valid[3]      = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, res_valid, core_rst_n, core_start_solve, core_load_valid, cl_ready}, 0);
        chk("mid_rst_res", {res_code, res_client, res_conflicts, res_decisions}, 0);
        chk("mid_rst_lit", core_load_literal, 0);
        cl_valid[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer is back at 0, so with 2 and 3 requesting the grant goes to 2
        tb_lit = '{1, 2, -1, 2};
        tb_ce  = '{0, 1, 0, 1};
        run_job(2, 4'b1100, 1'b0, 1'b1, 32'd2, 32'd3, 2, 32'd0, RES_SAT);

        chk("multi_ready", mon_multi_rdy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mini_job_sequencer.md
# mini_job_sequencer

Job scheduler that shares one `mini_solver_core` among `NUM_CLIENTS` requesters. Per job it:
- picks a client round-robin;
- resets the core;
- streams the client's clause literals into the core load port;
- pulses start;
- watches for completion or a cycle-budget timeout;
- returns the result and stats to the winning client.

It sits directly above the core in the Mini hierarchy and is the only driver of the core's control and load ports.

## Interface
Parameters:
- `NUM_CLIENTS`, 4, number of requesters (≥2)
- `TIMEOUT_W`, 32, width of the cycle-budget counter
- `CORE_RST_CYCLES`, 4, cycles `core_rst_n` is held low per job (≥1)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `req` in `NUM_CLIENTS`: job request, level, one per client
- `cl_valid` in `NUM_CLIENTS`: literal valid per client
- `cl_literal` in `NUM_CLIENTS`×32: signed literal per client
- `cl_clause_end` in `NUM_CLIENTS`: last literal of a clause
- `cl_last` in `NUM_CLIENTS`: last literal of the problem; valid only with `cl_clause_end`
- `cl_ready` out `NUM_CLIENTS`: literal accepted per client
- `cycle_budget` in `TIMEOUT_W`: solve-cycle limit; 0 = unlimited
- `res_valid` out 1, `res_ready` in 1: result handshake
- `res_client` out `$clog2(NUM_CLIENTS)`: client the result belongs to
- `res_code` out 2: `RES_SAT` / `RES_UNSAT` / `RES_TIMEOUT`
- `res_conflicts` out 32, `res_decisions` out 32: core stats
- `busy` out 1: a job is in progress
- `core_rst_n` out 1, `core_start_solve` out 1: core control
- `core_done` in 1, `core_sat` in 1, `core_unsat` in 1: core status
- `core_load_valid` out 1, `core_load_literal` out 32, `core_load_clause_end` out 1, `core_load_ready` in 1: core load stream
- `core_conflict_count` in 32, `core_decision_count` in 32: core stats

## Operation
FSM states: IDLE → CORE_RST → LOAD → START → SOLVE → REPORT → IDLE.

- **IDLE**
  - If any `req` bit is set: grant the first requester strictly after the last-granted index, wrapping. After reset the search starts at index 0.
  - Latch the grant index and go to CORE_RST.
- **CORE_RST**
  - Drive `core_rst_n`=0 for `CORE_RST_CYCLES` cycles, then release it for exactly one settle cycle.
  - Then go to LOAD.
- **LOAD**
  - Combinational pass-through from the granted client only:
    - `core_load_valid` = `cl_valid[g]`
    - `core_load_literal` = `cl_literal[g]`
    - `core_load_clause_end` = `cl_clause_end[g]`
    - `cl_ready[g]` = `core_load_ready`
  - All other `cl_ready` bits are 0.
  - A transfer occurs when valid and ready are both high.
  - On the transfer with `cl_last[g]`=1 (and `cl_clause_end[g]`=1), go to START.
- **START**
  - `core_start_solve`=1 for exactly one cycle.
  - Latch `cycle_budget`, clear the cycle counter, go to SOLVE.
- **SOLVE**
  - The counter increments each cycle.
  - On `core_done`: set `res_code` = `RES_SAT` if `core_sat`, else `RES_UNSAT`. Latch both stat counters, go to REPORT.
  - If the counter equals a nonzero budget and `core_done`=0: set `res_code` = `RES_TIMEOUT`, latch the stats, go to REPORT.
  - If `core_done` and the budget expiry fall in the same cycle, `core_done` wins.
- **REPORT**
  - Hold `res_valid`=1 with stable `res_*` until `res_ready`.
  - On the handshake, update the round-robin pointer to the granted index and go to IDLE.
- **Request handling**
  - `req[g]` may drop after grant; the job still completes.
  - A client dropping `req` during LOAD is a protocol error; the sequencer keeps waiting for `cl_last`.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset values:** all outputs 0 except `core_rst_n`=0. `core_rst_n` stays 0 while `rst_n`=0 and is released only via CORE_RST.
- **Reset mid-job:** state returns to IDLE, the pointer returns to 0, and no partial result is emitted.
- **Latency:**
  - IDLE with req → first LOAD cycle: `CORE_RST_CYCLES`+2 cycles.
  - Last literal accepted → `core_start_solve`: 1 cycle.
  - `core_done` → `res_valid`: 1 cycle.
- **Timeout:** reported on the cycle after the counter reaches the budget, i.e. budget B → `res_valid` B+1 cycles after the START cycle.
- **Back-to-back jobs:** a new grant can happen the cycle after the REPORT handshake.
- **Counter:** `TIMEOUT_W`-bit, saturating; never wraps.

## Configuration
- **`MINI_SEQ_TIMEOUT_EN` defined:** budget counter and `RES_TIMEOUT` path present as described.
- **Undefined:**
  - `cycle_budget` is ignored and the counter is removed.
  - SOLVE exits only on `core_done`.
  - `res_code` never equals `RES_TIMEOUT`.

## Structure
- **`mini_pkg` additions:**
  - `seq_state_t` enum (IDLE, CORE_RST, LOAD, START, SOLVE, REPORT).
  - `res_code_t`: `RES_NONE`=0, `RES_SAT`=1, `RES_UNSAT`=2, `RES_TIMEOUT`=3.
- **Sub-module `mini_rr_arbiter`:**
  - Inputs: `req` vector, `last` index, `advance` strobe.
  - Outputs: `grant` index, `grant_valid`.
  - Purely for round-robin selection.

## Test plan
- **Single SAT job:** client 0 loads (1 2)(-1 2), budget 0 → one `core_start_solve` pulse; `res_code`=SAT, `res_client`=0, stats equal core counters.
- **UNSAT job:** client 2 loads (1)(-1) → `res_code`=UNSAT, `res_conflicts` ≥ 1, client 2 `cl_ready` was the only ready bit asserted.
- **Fairness:** `req`=4'b1111 held for 8 jobs → grant order 0,1,2,3,0,1,2,3.
- **Timeout (`MINI_SEQ_TIMEOUT_EN`):** hard 20-var UNSAT, budget 5 → `RES_TIMEOUT` exactly 6 cycles after START. Next job runs after a fresh core reset.
- **Done/timeout tie:** force `core_done` on the budget cycle → `RES_SAT`/`RES_UNSAT`, not `RES_TIMEOUT`.
- **Reset mid-LOAD:** assert `rst_n`=0 during LOAD → all outputs 0, `core_rst_n`=0. After release the first grant goes to the lowest requesting index.
